// File: rtl/btn_pkg.sv
// Shared constants for the button conditioner.
// Defaults are derived from the 25 MHz board clock.
// Channel index names follow the snake game control layout.
package btn_pkg;

  localparam int CLK_HZ = 25_000_000;

  // 10 ms debounce window
  localparam int DEBOUNCE_VAL_DEF = CLK_HZ / 100;
  // 0.5 s before the first repeat, then 10 repeats per second
  localparam int REPEAT_DELAY_DEF = CLK_HZ / 2;
  localparam int REPEAT_RATE_DEF  = CLK_HZ / 10;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel:
//   - 2-flop synchroniser
//   - symmetric debounce counter and stable level
//   - registered press/release pulses
//   - optional auto-repeat down-counter
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   btn_i       : raw active-high button (asynchronous)
//   level_o     : debounced level
//   press_o     : one-cycle pulse on press and on each repeat
//   release_o   : one-cycle pulse on release
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int COUNTER_BIT  = 18,
  parameter int DEBOUNCE_VAL = 5,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_BIT   = 24,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [COUNTER_BIT-1:0] DB_MAX = COUNTER_BIT'(DEBOUNCE_VAL);

  logic                   sync1_q, sync2_q;
  logic                   stable_q, stable_d;
  logic [COUNTER_BIT-1:0] cnt_q, cnt_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   rise, fall, rpt_due;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Counter saturates at DB_MAX; the level flips on the sample after it
  // gets there, so it never wraps.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == DB_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign rise      = stable_d & ~stable_q;
  assign fall      = ~stable_d & stable_q;
  // A release in the same cycle as a due repeat suppresses the repeat.
  assign press_d   = rise | (rpt_due & ~fall);
  assign release_d = fall;

  if (REPEAT_EN != 0) begin : g_rpt
    localparam logic [REPEAT_BIT-1:0] DELAY_LD = REPEAT_BIT'(REPEAT_DELAY - 1);
    localparam logic [REPEAT_BIT-1:0] RATE_LD  = REPEAT_BIT'(REPEAT_RATE - 1);

    logic [REPEAT_BIT-1:0] rpt_q, rpt_d;

    // Down-counter: loaded on press, terminal count marks a due repeat
    // and reloads with the repeat period.
    always_comb begin
      rpt_d = rpt_q;
      if (rise) begin
        rpt_d = DELAY_LD;
      end else if (stable_q) begin
        rpt_d = (rpt_q == '0) ? RATE_LD : rpt_q - 1'b1;
      end
    end

    assign rpt_due = stable_q & (rpt_q == '0);

    always_ff @(posedge clk) begin
      if (reset) begin
        rpt_q <= '0;
      end else begin
        rpt_q <= rpt_d;
      end
    end
  end else begin : g_no_rpt
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{REPEAT_BIT, REPEAT_DELAY, REPEAT_RATE};
    assign rpt_due        = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   btn_in       : raw button pins (polarity set by ACTIVE_LOW)
//   btn_out      : debounced levels, 1 = pressed
//   press_out    : one-cycle press / auto-repeat pulses
//   release_out  : one-cycle release pulses
//   any_press    : OR of press_out
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int NUM_BTN      = 4,
  parameter int COUNTER_BIT  = 18,
  parameter int DEBOUNCE_VAL = 5,
  parameter int ACTIVE_LOW   = 0,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_BIT   = 24,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_out,
  output logic [NUM_BTN-1:0] press_out,
  output logic [NUM_BTN-1:0] release_out,
  output logic               any_press
);

  logic [NUM_BTN-1:0] btn_pol;

  assign btn_pol = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce_chan #(
      .COUNTER_BIT (COUNTER_BIT),
      .DEBOUNCE_VAL(DEBOUNCE_VAL),
      .REPEAT_EN   (REPEAT_EN),
      .REPEAT_BIT  (REPEAT_BIT),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .btn_i    (btn_pol[i]),
      .level_o  (btn_out[i]),
      .press_o  (press_out[i]),
      .release_o(release_out[i])
    );
  end

  // OR of registered pulses, so it lines up with press_out.
  assign any_press = |press_out;

endmodule

// File: tb/tb_btn_debounce_multi.sv
module tb_btn_debounce_multi;

  localparam int NB = 4;
  localparam int DV = 3;
  localparam int RD = 10;
  localparam int RR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = '0;
  logic [NB-1:0] pins1;

  logic [NB-1:0] lvl0, prs0, rel0, lvl1, prs1, rel1;
  logic          any0, any1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign pins1 = ~btn;

  // dut0: active-high pins, no repeat.  dut1: active-low pins, repeat on.
  btn_debounce_multi #(
    .NUM_BTN(NB), .COUNTER_BIT(4), .DEBOUNCE_VAL(DV), .ACTIVE_LOW(0),
    .REPEAT_EN(0), .REPEAT_BIT(8), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut0 (
    .clk(clk), .reset(rst), .btn_in(btn), .btn_out(lvl0),
    .press_out(prs0), .release_out(rel0), .any_press(any0)
  );

  btn_debounce_multi #(
    .NUM_BTN(NB), .COUNTER_BIT(4), .DEBOUNCE_VAL(DV), .ACTIVE_LOW(1),
    .REPEAT_EN(1), .REPEAT_BIT(8), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut1 (
    .clk(clk), .reset(rst), .btn_in(pins1), .btn_out(lvl1),
    .press_out(prs1), .release_out(rel1), .any_press(any1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The level flips once the last DV+1 synchronised samples all
  // disagree with it; synchronised sample = pin value two edges ago.
  // Repeats are due at press+RD, press+RD+k*RR while held.
  logic [NB-1:0] m_p1, m_p2, m_st, m_prs0, m_prs1, m_rel;
  logic [NB-1:0] win[$];
  int            tp[NB];

  task automatic m_step(input logic r, input logic [NB-1:0] b);
    logic [NB-1:0] s, nxt;
    bit all_diff, rise, fall, rep;
    if (r) begin
      m_p1 = '0; m_p2 = '0; m_st = '0;
      m_prs0 = '0; m_prs1 = '0; m_rel = '0;
      win.delete();
      for (int c = 0; c < NB; c++) tp[c] = 0;
    end else begin
      s = m_p2; m_p2 = m_p1; m_p1 = b;
      win.push_back(s);
      if (win.size() > DV + 1) win.delete(0);
      nxt = m_st;
      for (int c = 0; c < NB; c++) begin
        all_diff = (win.size() == DV + 1);
        for (int j = 0; j < win.size(); j++)
          if (win[j][c] == m_st[c]) all_diff = 0;
        if (all_diff) nxt[c] = ~m_st[c];
      end
      for (int c = 0; c < NB; c++) begin
        rise = nxt[c] & ~m_st[c];
        fall = ~nxt[c] & m_st[c];
        rep  = 0;
        if (rise) tp[c] = 0;
        else if (m_st[c] && nxt[c]) begin
          tp[c]++;
          rep = (tp[c] == RD) || (tp[c] > RD && ((tp[c] - RD) % RR) == 0);
        end
        m_prs0[c] = rise;
        m_prs1[c] = rise | rep;
        m_rel[c]  = fall;
      end
      m_st = nxt;
    end
  endtask

  always @(posedge clk) begin
    m_step(rst, btn);
    #1;
    chk("model_lvl0", 32'(lvl0), 32'(m_st));
    chk("model_prs0", 32'(prs0), 32'(m_prs0));
    chk("model_rel0", 32'(rel0), 32'(m_rel));
    chk("model_any0", 32'(any0), 32'(|m_prs0));
    chk("model_lvl1", 32'(lvl1), 32'(m_st));
    chk("model_prs1", 32'(prs1), 32'(m_prs1));
    chk("model_rel1", 32'(rel1), 32'(m_rel));
    chk("model_any1", 32'(any1), 32'(|m_prs1));
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic          r;
    logic [NB-1:0] b;
    logic [NB-1:0] e_lvl;
    logic [NB-1:0] e_prs;
    logic [NB-1:0] e_rel;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic [NB-1:0] b, input logic [NB-1:0] l,
                     input logic [NB-1:0] p, input logic [NB-1:0] rl, input int n);
    vec_t v;
    v.r = r; v.b = b; v.e_lvl = l; v.e_prs = p; v.e_rel = rl;
    for (int k = 0; k < n; k++) vt.push_back(v);
  endtask

  // Drive before an edge; results are sampled 2 time units after it.
  task automatic step(input logic r, input logic [NB-1:0] b);
    @(negedge clk);
    rst = r;
    btn = b;
    @(posedge clk);
    #2;
  endtask

  int pq[$], rq[$], pq0[$];
  int exp_p[$];

  initial begin
    // clean press on ch0
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 2);
    add(0, 4'h1, 4'h0, 4'h0, 4'h0, 5);
    add(0, 4'h1, 4'h1, 4'h1, 4'h0, 1);
    add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4);
    // release bounce: 2 low cycles are ignored
    add(0, 4'h0, 4'h1, 4'h0, 4'h0, 2);
    add(0, 4'h1, 4'h1, 4'h0, 4'h0, 6);
    // steady release
    add(0, 4'h0, 4'h1, 4'h0, 4'h0, 5);
    add(0, 4'h0, 4'h0, 4'h0, 4'h1, 1);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 3);
    // 3-cycle glitch on ch1 is rejected
    add(0, 4'h2, 4'h0, 4'h0, 4'h0, 3);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 8);
    // 5-cycle pulse on ch1 passes
    add(0, 4'h2, 4'h0, 4'h0, 4'h0, 5);
    add(0, 4'h0, 4'h2, 4'h2, 4'h0, 1);
    add(0, 4'h0, 4'h2, 4'h0, 4'h0, 4);
    add(0, 4'h0, 4'h0, 4'h0, 4'h2, 1);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 2);

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].r, vt[i].b);
      chk($sformatf("vec%0d_lvl", i), 32'(lvl0), 32'(vt[i].e_lvl));
      chk($sformatf("vec%0d_prs", i), 32'(prs0), 32'(vt[i].e_prs));
      chk($sformatf("vec%0d_rel", i), 32'(rel0), 32'(vt[i].e_rel));
      chk($sformatf("vec%0d_any", i), 32'(any0), 32'(|vt[i].e_prs));
    end

    // auto-repeat, with release landing on a due repeat (edge 40)
    step(1, 4'h0); step(1, 4'h0);
    for (int e = 1; e <= 55; e++) begin
      step(0, (e <= 34) ? 4'h1 : 4'h0);
      if (prs1[0]) pq.push_back(e);
      if (rel1[0]) rq.push_back(e);
      if (prs0[0]) pq0.push_back(e);
    end
    exp_p = '{6, 16, 20, 24, 28, 32, 36};
    chk("rpt_press_count", 32'(pq.size()), 32'(exp_p.size()));
    for (int k = 0; k < exp_p.size() && k < pq.size(); k++)
      chk($sformatf("rpt_press_edge%0d", k), 32'(pq[k]), 32'(exp_p[k]));
    chk("rpt_release_count", 32'(rq.size()), 32'd1);
    if (rq.size() > 0) chk("rpt_release_edge", 32'(rq[0]), 32'd40);
    chk("norpt_press_count", 32'(pq0.size()), 32'd1);
    if (pq0.size() > 0) chk("norpt_press_edge", 32'(pq0[0]), 32'd6);

    // simultaneous press on ch2/ch3 through active-low pins
    step(1, 4'h0); step(1, 4'h0);
    for (int e = 1; e <= 6; e++) begin
      step(0, 4'hC);
      chk($sformatf("simul_prs_e%0d", e), 32'(prs1), (e == 6) ? 32'hC : 32'h0);
      chk($sformatf("simul_any_e%0d", e), 32'(any1), (e == 6) ? 32'h1 : 32'h0);
    end

    // reset while held, then fresh press with no release
    step(1, 4'h0);
    for (int e = 1; e <= 8; e++) step(0, 4'h1);
    chk("rst_pre_lvl", 32'(lvl0), 32'h1);
    step(1, 4'h1);
    chk("rst_lvl0", 32'(lvl0), 32'h0);
    chk("rst_lvl1", 32'(lvl1), 32'h0);
    chk("rst_prs", 32'({prs0, prs1}), 32'h0);
    chk("rst_rel", 32'({rel0, rel1}), 32'h0);
    chk("rst_any", 32'({any0, any1}), 32'h0);
    for (int e = 1; e <= 8; e++) begin
      step(0, 4'h1);
      chk($sformatf("postrst_prs_e%0d", e), 32'(prs0), (e == 6) ? 32'h1 : 32'h0);
      chk($sformatf("postrst_rel_e%0d", e), 32'(rel0 | rel1), 32'h0);
      chk($sformatf("postrst_lvl_e%0d", e), 32'(lvl0), (e >= 6) ? 32'h1 : 32'h0);
    end

    // randomized: bouncy phase, then slow phase so repeats occur
    for (int n = 0; n < 2000; n++) begin
      logic [NB-1:0] b;
      logic r;
      int odds;
      b = btn;
      odds = (n < 1000) ? 5 : 40;
      for (int c = 0; c < NB; c++)
        if ($urandom_range(0, odds) == 0) b[c] = ~b[c];
      r = ($urandom_range(0, 299) == 0);
      step(r, b);
    end

    step(0, btn);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
